data_mem_lsu: RTL and testbench

- Parametrised successor to the single-cycle data memory for the RV32 cores. It adds true byte-addressed sub-word access at any legal offset, misalignment and range checking, and a valid/ready request port.
- Responses use a fixed, configurable latency, so the same block serves both the single-cycle core and the upcoming multi-cycle/pipelined cores.
- Memory is word-organised internally (32-bit words); stores use per-byte lane enables.

---
 rtl/data_mem_lsu.sv | 140 ++++++++++++++
 tb/tb_data_mem_lsu.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// Word-organised data memory with byte-lane stores, alignment/range checking,
// a valid/ready request port and a fixed, parameterised response latency.
module data_mem_lsu #(
    parameter int DEPTH_WORDS = 64,
    parameter int LAT         = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  mem_read,
    input  logic [1:0]  mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LAT > 2) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LAT > 1) ? LAT - 2 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [31:0]     mem [DEPTH_WORDS];
    logic [31:0]     pend_data;
    logic            pend_err;
    logic            accept;
    logic [AW-1:0]   word_idx;
    logic [1:0]      off;
    logic            range_err, code_err, align_err, req_err;
    logic [31:0]     rd_word, wr_data, ld_data, cur_data;
    logic [3:0]      be;
    logic [15:0]     half;
    logic [7:0]      lane_byte;

    assign req_ready = (state != BUSY);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid && req_ready;
    assign word_idx  = addr[AW+1:2];
    assign off       = addr[1:0];
    assign range_err = |addr[31:AW+2];
    assign rd_word   = mem[word_idx];

    always_comb begin
        code_err  = (mem_read[2:1] == 2'b11) || (mem_read != 3'b000 && mem_write != 2'b00);
        align_err = ((mem_read == 3'b001 || mem_write == 2'b01) && off != 2'b00) ||
                    ((mem_read == 3'b010 || mem_read == 3'b011 || mem_write == 2'b10) && off[0]);
        req_err   = code_err || align_err || range_err;
    end

    // Load path works straight off the array so a store from the previous edge is visible.
    always_comb begin
        ld_data   = '0;
        half      = addr[1] ? rd_word[31:16] : rd_word[15:0];
        lane_byte = rd_word[8*off +: 8];
        case (mem_read)
            3'b001:  ld_data = rd_word;
            3'b010:  ld_data = {{16{half[15]}}, half};
            3'b011:  ld_data = {16'b0, half};
            3'b100:  ld_data = {{24{lane_byte[7]}}, lane_byte};
            3'b101:  ld_data = {24'b0, lane_byte};
            default: ld_data = '0;
        endcase
        cur_data = req_err ? '0 : ld_data;
    end

    always_comb begin
        be      = '0;
        wr_data = wdata;
        case (mem_write)
            2'b01: be = 4'b1111;
            2'b10: begin
                be      = off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{wdata[15:0]}};
            end
            2'b11: begin
                be      = 4'b0001 << off;
                wr_data = {4{wdata[7:0]}};
            end
            default: be = '0;
        endcase
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept && !rst && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LAT == 1) next_state = RESP;
                    else          next_state = BUSY;
                end else if (state == RESP) begin
                    next_state = IDLE;
                end
            end
            BUSY:    if (cnt == '0) next_state = RESP;
            default: next_state = IDLE;
        endcase
    end

    // Outputs load only on entry to RESP; from BUSY the held result is used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_data <= '0;
            pend_err  <= 1'b0;
            rdata     <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                cnt       <= CNT_INIT;
                pend_data <= cur_data;
                pend_err  <= req_err;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (next_state == RESP) begin
                rdata   <= (state == BUSY) ? pend_data : cur_data;
                rsp_err <= (state == BUSY) ? pend_err  : req_err;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: a LAT=1 and a LAT=3 instance, checked against an
// arithmetic memory model with directed and randomised requests.
module tb_data_mem_lsu;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  mem_read  = '0;
    logic [1:0]  mem_write = '0;
    logic [31:0] addr      = '0;
    logic [31:0] wdata     = '0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        rsp_valid [2];
    logic [31:0] rdata     [2];
    logic        rsp_err   [2];

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model [2][DEPTH];
    logic [31:0] last_rdata;
    logic        last_err;
    logic [31:0] last_exp_d [2];
    logic        last_exp_e [2];

    always #5 clk = ~clk;

    data_mem_lsu #(.DEPTH_WORDS(DEPTH), .LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid[0]), .rdata(rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_lsu #(.DEPTH_WORDS(DEPTH), .LAT(3)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
        .rsp_valid(rsp_valid[1]), .rdata(rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: memory as an array of words, lanes by shift/mask arithmetic.
    task automatic model_req(input int sel, input logic [2:0] rd, input logic [1:0] wr,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic e, output logic [31:0] d);
        int          w, o;
        logic [31:0] word, mask, part;
        e = (rd >= 3'd6) || (rd != 3'd0 && wr != 2'd0) || (a >= 32'(4 * DEPTH)) ||
            ((rd == 3'd1 || wr == 2'd1) && (a % 4) != 0) ||
            ((rd == 3'd2 || rd == 3'd3 || wr == 2'd2) && (a % 2) != 0);
        d = '0;
        if (e) return;
        w    = int'(a / 4);
        o    = int'(a % 4);
        word = model[sel][w];
        mask = '0;
        case (wr)
            2'd1: model[sel][w] = wd;
            2'd2: begin
                mask = 32'hFFFF << (8 * o);
                model[sel][w] = (word & ~mask) | ((wd & 32'hFFFF) << (8 * o));
            end
            2'd3: begin
                mask = 32'hFF << (8 * o);
                model[sel][w] = (word & ~mask) | ((wd & 32'hFF) << (8 * o));
            end
            default: ;
        endcase
        case (rd)
            3'd1: d = word;
            3'd2, 3'd3: begin
                part = (word >> (8 * o)) & 32'hFFFF;
                d = (rd == 3'd2 && part >= 32'h8000) ? part - 32'h10000 : part;
            end
            3'd4, 3'd5: begin
                part = (word >> (8 * o)) & 32'hFF;
                d = (rd == 3'd4 && part >= 32'h80) ? part - 32'h100 : part;
            end
            default: ;
        endcase
    endtask

    // Called at a falling edge; returns at the falling edge inside the response cycle.
    task automatic apply_stimulus(input int sel, input int lat, input logic [2:0] rd,
                                  input logic [1:0] wr, input logic [31:0] a,
                                  input logic [31:0] wd, input string tag);
        logic        e;
        logic [31:0] d;
        mem_read       = rd;
        mem_write      = wr;
        addr           = a;
        wdata          = wd;
        req_valid[sel] = 1'b1;
        check({tag, "_ready"}, 32'(req_ready[sel]), 32'd1);
        @(posedge clk);
        model_req(sel, rd, wr, a, wd, e, d);
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                check({tag, "_busy_ready"}, 32'(req_ready[sel]), 32'd0);
                check({tag, "_busy_valid"}, 32'(rsp_valid[sel]), 32'd0);
            end else begin
                req_valid[sel] = 1'b0;
                check({tag, "_valid"}, 32'(rsp_valid[sel]), 32'd1);
                check({tag, "_rdata"}, rdata[sel], d);
                check({tag, "_err"}, 32'(rsp_err[sel]), 32'(e));
                check({tag, "_resp_ready"}, 32'(req_ready[sel]), 32'd1);
                last_rdata      = rdata[sel];
                last_err        = rsp_err[sel];
                last_exp_d[sel] = d;
                last_exp_e[sel] = e;
            end
        end
    endtask

    // One idle cycle: no response may appear and the previous result must hold.
    task automatic check_output(input int sel, input string tag);
        @(negedge clk);
        check({tag, "_idle_valid"}, 32'(rsp_valid[sel]), 32'd0);
        check({tag, "_hold_rdata"}, rdata[sel], last_exp_d[sel]);
        check({tag, "_hold_err"}, 32'(rsp_err[sel]), 32'(last_exp_e[sel]));
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int s = 0; s < 2; s++) begin
            check({tag, "_valid"}, 32'(rsp_valid[s]), 32'd0);
            check({tag, "_ready"}, 32'(req_ready[s]), 32'd1);
            check({tag, "_rdata"}, rdata[s], 32'd0);
            check({tag, "_err"}, 32'(rsp_err[s]), 32'd0);
        end
    endtask

    initial begin
        logic [2:0]  rd;
        logic [1:0]  wr;
        logic [31:0] a;
        int          k, lat;

        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            last_exp_d[s] = '0;
            last_exp_e[s] = 1'b0;
            for (int w = 0; w < DEPTH; w++) model[s][w] = '0;
        end

        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        apply_stimulus(0, 1, 3'd0, 2'd1, 32'h10, 32'hDEADBEEF, "b2b_sw");
        apply_stimulus(0, 1, 3'd1, 2'd0, 32'h10, 32'h0, "b2b_lw");
        check("b2b_lw_const", last_rdata, 32'hDEADBEEF);

        apply_stimulus(0, 1, 3'd0, 2'd1, 32'h20, 32'h11223344, "lane_sw");
        apply_stimulus(0, 1, 3'd0, 2'd3, 32'h22, 32'h000000AA, "lane_sb");
        apply_stimulus(0, 1, 3'd1, 2'd0, 32'h20, 32'h0, "lane_lw");
        check("lane_lw_const", last_rdata, 32'h11AA3344);
        apply_stimulus(0, 1, 3'd4, 2'd0, 32'h22, 32'h0, "lane_lb");
        check("lane_lb_const", last_rdata, 32'hFFFFFFAA);
        apply_stimulus(0, 1, 3'd5, 2'd0, 32'h22, 32'h0, "lane_lbu");
        check("lane_lbu_const", last_rdata, 32'h000000AA);
        apply_stimulus(0, 1, 3'd2, 2'd0, 32'h22, 32'h0, "lane_lh");
        check("lane_lh_const", last_rdata, 32'h000011AA);
        check_output(0, "lane");

        apply_stimulus(0, 1, 3'd0, 2'd1, 32'h0, 32'h0BADF00D, "w0_sw");
        apply_stimulus(0, 1, 3'd1, 2'd0, 32'h21, 32'h0, "mis_lw");
        check("mis_lw_err", 32'(last_err), 32'd1);
        check("mis_lw_rdata", last_rdata, 32'd0);
        apply_stimulus(0, 1, 3'd0, 2'd2, 32'h23, 32'h00005555, "mis_sh");
        check("mis_sh_err", 32'(last_err), 32'd1);
        apply_stimulus(0, 1, 3'd0, 2'd1, 32'h100, 32'hCAFEF00D, "range_sw");
        check("range_sw_err", 32'(last_err), 32'd1);
        apply_stimulus(0, 1, 3'd1, 2'd0, 32'h20, 32'h0, "mis_follow_lw");
        check("mis_follow_const", last_rdata, 32'h11AA3344);
        apply_stimulus(0, 1, 3'd1, 2'd0, 32'h0, 32'h0, "range_follow_lw");
        check("range_follow_const", last_rdata, 32'h0BADF00D);

        apply_stimulus(0, 1, 3'd6, 2'd0, 32'h20, 32'h0, "ill_rd");
        check("ill_rd_err", 32'(last_err), 32'd1);
        apply_stimulus(0, 1, 3'd1, 2'd1, 32'h20, 32'h99999999, "ill_both");
        check("ill_both_err", 32'(last_err), 32'd1);
        apply_stimulus(0, 1, 3'd1, 2'd0, 32'h20, 32'h0, "ill_follow_lw");
        check("ill_follow_const", last_rdata, 32'h11AA3344);
        check_output(0, "ill");

        apply_stimulus(1, 3, 3'd0, 2'd1, 32'h40, 32'h12345678, "l3_sw");
        apply_stimulus(1, 3, 3'd1, 2'd0, 32'h40, 32'h0, "l3_lw");
        check("l3_lw_const", last_rdata, 32'h12345678);
        check_output(1, "l3");
        apply_stimulus(1, 3, 3'd0, 2'd1, 32'h44, 32'hA5A5A5A5, "l3_sw2");
        apply_stimulus(1, 3, 3'd1, 2'd0, 32'h44, 32'h0, "l3_lw2");
        check("l3_lw2_const", last_rdata, 32'hA5A5A5A5);

        mem_read     = 3'd1;
        mem_write    = 2'd0;
        addr         = 32'h40;
        req_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_busy", 32'(req_ready[1]), 32'd0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        req_valid[1] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            last_exp_d[s] = '0;
            last_exp_e[s] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) check_output(1, "rst_drop");
        apply_stimulus(1, 3, 3'd1, 2'd0, 32'h40, 32'h0, "rst_keep_lw");
        check("rst_keep_const", last_rdata, 32'h12345678);

        for (int sel = 0; sel < 2; sel++) begin
            lat = (sel == 0) ? 1 : 3;
            for (int w = 0; w < DEPTH; w++)
                apply_stimulus(sel, lat, 3'd0, 2'd1, 32'(4 * w), $urandom(), "fill");
            for (int n = 0; n < 120; n++) begin
                k = int'($urandom_range(0, 9));
                if (k < 4) begin
                    rd = 3'($urandom_range(1, 5));
                    wr = 2'd0;
                end else if (k < 8) begin
                    rd = 3'd0;
                    wr = 2'($urandom_range(1, 3));
                end else if (k == 8) begin
                    rd = 3'd0;
                    wr = 2'd0;
                end else begin
                    rd = 3'($urandom_range(0, 7));
                    wr = 2'($urandom_range(0, 3));
                end
                if ((rd != 3'd0 || wr != 2'd0) && $urandom_range(0, 15) == 0)
                    a = $urandom() | (32'd1 << $urandom_range(8, 31));
                else
                    a = 32'($urandom_range(0, 4 * DEPTH - 1));
                apply_stimulus(sel, lat, rd, wr, a, $urandom(), "rnd");
                if ($urandom_range(0, 3) == 0) check_output(sel, "rnd");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
